// File: rtl/grad_step_seq.sv
// grad_step_seq: finite-difference gradient step engine.
// Time-shares one external evaluator: f(x), then optionally f(x+h), then
// f(x-h), and from those forms value = f(x), gradient = df/dx and the
// saturated update step x_diff = LEARNING_RATE * gradient.
//
// Optional feature macro: GRAD_STEP_CENTRAL_EN
//   defined   -> mode=1 selects central difference (adds the EVAL_P state)
//   undefined -> mode is ignored, backward difference only
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, mode, x_in request (sampled in IDLE), difference mode, point x
//   busy, done        operation in progress, one-cycle completion pulse
//   value, gradient   f(x) and df/dx (Q(YW).FRAC)
//   x_diff            clamped LEARNING_RATE * gradient
//   overflow, err     any overflow/saturation/clamp, evaluator timeout
//   eval_start/eval_x request pulse and operand to the evaluator
//   eval_y/eval_done/eval_ovf  evaluator response
//
// state   | meaning
// IDLE    | waiting for start
// EVAL_C  | evaluating f(x)
// EVAL_P  | evaluating f(x+h) (central only)
// EVAL_M  | evaluating f(x-h)
// CALC    | difference, scaling and clamp; results registered on exit
// DONE    | done pulse, results valid
module grad_step_seq #(
  parameter int            XW            = 32,
  parameter int            YW            = 64,
  parameter int            FRAC          = 8,
  parameter int            STEP_LOG2     = 1,
  parameter logic [XW-1:0] LEARNING_RATE = 32'h00000020,
  parameter int            TIMEOUT       = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [XW-1:0]      x_in,
  output logic               busy,
  output logic               done,
  output logic [YW-1:0]      value,
  output logic [YW+FRAC-1:0] gradient,
  output logic [XW-1:0]      x_diff,
  output logic               overflow,
  output logic               err,
  output logic               eval_start,
  output logic [XW-1:0]      eval_x,
  input  logic [YW-1:0]      eval_y,
  input  logic               eval_done,
  input  logic               eval_ovf
);

  localparam int GW   = YW + FRAC;
  localparam int PW   = XW + YW + FRAC;
  localparam int TW   = $clog2(TIMEOUT);
  localparam int SH_B = FRAC - STEP_LOG2;
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [XW:0]   H_EXT  = (XW+1)'(1) << STEP_LOG2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EVAL_C = 3'd1,
`ifdef GRAD_STEP_CENTRAL_EN
    S_EVAL_P = 3'd2,
`endif
    S_EVAL_M = 3'd3,
    S_CALC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // {saturated flag, value}: clamp an XW+1 bit sum back into XW bits
  function automatic logic [XW:0] sat_op(input logic [XW:0] s);
    if (s[XW] != s[XW-1]) sat_op = {1'b1, s[XW], {(XW-1){~s[XW]}}};
    else                  sat_op = {1'b0, s[XW-1:0]};
  endfunction

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_c_q, y_c_d, y_m_q, y_m_d;
  logic            ovf_acc_q, ovf_acc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [YW-1:0]   value_q, value_d;
  logic [GW-1:0]   grad_q, grad_d;
  logic [XW-1:0]   x_diff_q, x_diff_d;
  logic            ovf_q, ovf_d, err_q, err_d;
  logic            eval_start_q, eval_start_d;
  logic [XW-1:0]   eval_x_q, eval_x_d;
  logic            in_eval;

  logic [XW:0]          x_minus_sat;
  logic [YW-1:0]        diff_a;
  logic [YW:0]          diff;
  logic signed [GW-1:0] grad_ext, grad;
  logic signed [PW-1:0] prod, prod_sh;
  logic                 x_fit;
  logic [XW-1:0]        x_clamped;

`ifdef GRAD_STEP_CENTRAL_EN
  localparam int SH_C = FRAC - STEP_LOG2 - 1;
  logic          mode_q, mode_d;
  logic [YW-1:0] y_p_q, y_p_d;
  logic [XW:0]   x_plus_sat;

  assign x_plus_sat = sat_op({x_q[XW-1], x_q} + H_EXT);
  assign diff_a     = mode_q ? y_p_q : y_c_q;
  assign grad       = mode_q ? (grad_ext <<< SH_C) : (grad_ext <<< SH_B);
  assign in_eval    = (state_q == S_EVAL_C) || (state_q == S_EVAL_P) || (state_q == S_EVAL_M);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign diff_a      = y_c_q;
  assign grad        = grad_ext <<< SH_B;
  assign in_eval     = (state_q == S_EVAL_C) || (state_q == S_EVAL_M);
`endif

  assign x_minus_sat = sat_op({x_q[XW-1], x_q} - H_EXT);

  // YW+1 bit difference cannot wrap; sign-extended it leaves room for the shift
  assign diff     = {diff_a[YW-1], diff_a} - {y_m_q[YW-1], y_m_q};
  assign grad_ext = {{(GW-YW-1){diff[YW]}}, diff};

  assign prod    = $signed({{(YW+FRAC){LEARNING_RATE[XW-1]}}, LEARNING_RATE})
                 * $signed({{XW{grad[GW-1]}}, grad});
  assign prod_sh = prod >>> FRAC;
  // fits in XW bits when everything above the XW sign bit is sign extension
  assign x_fit     = (prod_sh[PW-1:XW-1] == {(PW-XW+1){prod_sh[XW-1]}});
  assign x_clamped = x_fit ? prod_sh[XW-1:0] : {prod_sh[PW-1], {(XW-1){~prod_sh[PW-1]}}};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_c_d        = y_c_q;
    y_m_d        = y_m_q;
    ovf_acc_d    = ovf_acc_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    value_d      = value_q;
    grad_d       = grad_q;
    x_diff_d     = x_diff_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    eval_start_d = 1'b0;
    eval_x_d     = eval_x_q;
`ifdef GRAD_STEP_CENTRAL_EN
    mode_d       = mode_q;
    y_p_d        = y_p_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        x_d          = x_in;
`ifdef GRAD_STEP_CENTRAL_EN
        mode_d       = mode;
`endif
        ovf_acc_d    = 1'b0;
        busy_d       = 1'b1;
        eval_start_d = 1'b1;
        eval_x_d     = x_in;
        timer_d      = T_LOAD;
        state_d      = S_EVAL_C;
      end
      S_EVAL_C: if (eval_done) begin
        y_c_d        = eval_y;
        eval_start_d = 1'b1;
        timer_d      = T_LOAD;
`ifdef GRAD_STEP_CENTRAL_EN
        if (mode_q) begin
          state_d   = S_EVAL_P;
          eval_x_d  = x_plus_sat[XW-1:0];
          ovf_acc_d = ovf_acc_q | eval_ovf | x_plus_sat[XW];
        end else begin
          state_d   = S_EVAL_M;
          eval_x_d  = x_minus_sat[XW-1:0];
          ovf_acc_d = ovf_acc_q | eval_ovf | x_minus_sat[XW];
        end
`else
        state_d   = S_EVAL_M;
        eval_x_d  = x_minus_sat[XW-1:0];
        ovf_acc_d = ovf_acc_q | eval_ovf | x_minus_sat[XW];
`endif
      end
`ifdef GRAD_STEP_CENTRAL_EN
      S_EVAL_P: if (eval_done) begin
        y_p_d        = eval_y;
        eval_start_d = 1'b1;
        timer_d      = T_LOAD;
        state_d      = S_EVAL_M;
        eval_x_d     = x_minus_sat[XW-1:0];
        ovf_acc_d    = ovf_acc_q | eval_ovf | x_minus_sat[XW];
      end
`endif
      S_EVAL_M: if (eval_done) begin
        y_m_d     = eval_y;
        ovf_acc_d = ovf_acc_q | eval_ovf;
        state_d   = S_CALC;
      end
      S_CALC: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        value_d  = y_c_q;
        grad_d   = grad;
        x_diff_d = x_clamped;
        ovf_d    = ovf_acc_q | ~x_fit;
        err_d    = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // evaluator silent for TIMEOUT cycles: abort with zeroed results
    if (in_eval && !eval_done) begin
      if (timer_q == '0) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        err_d    = 1'b1;
        ovf_d    = 1'b1;
        value_d  = '0;
        grad_d   = '0;
        x_diff_d = '0;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_c_q        <= '0;
      y_m_q        <= '0;
      ovf_acc_q    <= 1'b0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      value_q      <= '0;
      grad_q       <= '0;
      x_diff_q     <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      eval_start_q <= 1'b0;
      eval_x_q     <= '0;
`ifdef GRAD_STEP_CENTRAL_EN
      mode_q       <= 1'b0;
      y_p_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_c_q        <= y_c_d;
      y_m_q        <= y_m_d;
      ovf_acc_q    <= ovf_acc_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      value_q      <= value_d;
      grad_q       <= grad_d;
      x_diff_q     <= x_diff_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      eval_start_q <= eval_start_d;
      eval_x_q     <= eval_x_d;
`ifdef GRAD_STEP_CENTRAL_EN
      mode_q       <= mode_d;
      y_p_q        <= y_p_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign value      = value_q;
  assign gradient   = grad_q;
  assign x_diff     = x_diff_q;
  assign overflow   = ovf_q;
  assign err        = err_q;
  assign eval_start = eval_start_q;
  assign eval_x     = eval_x_q;

endmodule

// File: tb/tb_grad_step_seq.sv
`timescale 1ns/1ps
module tb_grad_step_seq;
  localparam int FRAC    = 8;
  localparam int H       = 2;          // 2**STEP_LOG2
  localparam int TIMEOUT = 16;
  typedef logic signed [127:0] wide_t;
  localparam wide_t  LR   = 128'sd32;
  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -64'sd2147483648;
`ifdef GRAD_STEP_CENTRAL_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [31:0] x_in = '0;
  logic busy, done, overflow, err, eval_start;
  logic [63:0] value;
  logic [71:0] gradient;
  logic [31:0] x_diff, eval_x;
  logic [63:0] eval_y;
  logic eval_done, eval_ovf;

  grad_step_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x_in(x_in),
    .busy(busy), .done(done), .value(value), .gradient(gradient),
    .x_diff(x_diff), .overflow(overflow), .err(err),
    .eval_start(eval_start), .eval_x(eval_x), .eval_y(eval_y),
    .eval_done(eval_done), .eval_ovf(eval_ovf)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // evaluator behaviour
  int lat_cfg = 1, fsel = 0;
  bit ovf_en = 0;
  logic [31:0] ref_x = '0;
  logic [63:0] ya = '0, yb = '0;
  logic signed [31:0] slope = 0;
  logic signed [63:0] offs = 0;

  function automatic logic [63:0] f_eval(input logic [31:0] x);
    case (fsel)
      0:       f_eval = 64'(3 * longint'($signed(x)));
      1:       f_eval = 64'(longint'(slope) * longint'($signed(x)) + offs);
      default: f_eval = (x == ref_x) ? ya : yb;
    endcase
  endfunction
  function automatic bit ovf_eval(input logic [31:0] x);
    return ovf_en && (^x[2:0]);
  endfunction

  initial begin : evaluator
    int cnt; bit pend; logic [31:0] px;
    cnt = 0; pend = 0; px = '0;
    eval_done = 0; eval_ovf = 0; eval_y = '0;
    forever begin
      @(posedge clk); #1;
      eval_done = 0;
      eval_ovf  = 1'($urandom_range(0, 1));
      eval_y    = {$urandom(), $urandom()};
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0; eval_done = 1; eval_y = f_eval(px); eval_ovf = ovf_eval(px);
        end
      end
      if (eval_start && lat_cfg > 0) begin pend = 1; cnt = lat_cfg; px = eval_x; end
    end
  end

  // expectations
  logic [31:0] exp_ex[$];
  logic [31:0] ex_log[$];
  logic [63:0] exp_value;
  logic [71:0] exp_grad;
  logic [31:0] exp_xd;
  bit exp_ovf, exp_err, op_active = 0;
  int exp_rel, start_cyc = 0, exp_done_cyc = -1, done_cnt = 0, last_rel = 0;

  task automatic model(input logic [31:0] x, input bit m, input int lat);
    bit c, ov; longint xs, xp, xm; wide_t yc, yp, ym, diff, gr, q;
    c = CB && m; ov = 0; yp = 0;
    xs = longint'($signed(x));
    exp_ex.push_back(x);
    yc = wide_t'($signed(f_eval(x))); ov |= ovf_eval(x);
    if (c) begin
      xp = xs + H;
      if (xp > XMAX) begin xp = XMAX; ov = 1; end
      exp_ex.push_back(32'(xp));
      yp = wide_t'($signed(f_eval(32'(xp)))); ov |= ovf_eval(32'(xp));
    end
    xm = xs - H;
    if (xm < XMIN) begin xm = XMIN; ov = 1; end
    exp_ex.push_back(32'(xm));
    ym = wide_t'($signed(f_eval(32'(xm)))); ov |= ovf_eval(32'(xm));
    diff = c ? yp - ym : yc - ym;
    gr = diff * wide_t'(2 ** FRAC) / wide_t'(c ? 2 * H : H);
    q = (LR * gr) >>> FRAC;
    if (q > XMAX)      begin exp_xd = 32'h7FFFFFFF; ov = 1; end
    else if (q < XMIN) begin exp_xd = 32'h80000000; ov = 1; end
    else exp_xd = q[31:0];
    exp_value = yc[63:0]; exp_grad = gr[71:0]; exp_ovf = ov; exp_err = 0;
    exp_rel = c ? 3 * lat + 5 : 2 * lat + 4;
  endtask

  task automatic model_timeout(input logic [31:0] x);
    exp_ex.push_back(x);
    exp_value = '0; exp_grad = '0; exp_xd = '0; exp_ovf = 1; exp_err = 1; exp_rel = -1;
  endtask

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      if (eval_start) begin
        ex_log.push_back(eval_x);
        if (exp_ex.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stray_eval_start: eval_x %0h, none expected", eval_x);
        end else chk("eval_x", eval_x, exp_ex.pop_front());
      end
      if (op_active && exp_done_cyc >= 0)
        chk("busy", busy, (cyc > start_cyc) && (cyc <= exp_done_cyc));
      else if (!op_active)
        chk("busy_idle", busy, 0);
      if (done) begin
        if (!op_active) begin
          n_vec++; n_err++;
          $display("FAIL stray_done: done=1 with no operation, expected 0");
        end else begin
          last_rel = cyc - start_cyc;
          if (exp_done_cyc >= 0) chk("done_cycle", last_rel, exp_done_cyc - start_cyc);
          chk("value", value, exp_value);
          chk("gradient", gradient, exp_grad);
          chk("x_diff", x_diff, exp_xd);
          chk("overflow", overflow, exp_ovf);
          chk("err", err, exp_err);
          done_cnt++;
          op_active = 0;
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input bit m, input int lat, input int hold);
    int n0; bit seen;
    lat_cfg = lat;
    @(negedge clk);
    exp_ex.delete(); ex_log.delete();
    if (lat > 0) model(x, m, lat); else model_timeout(x);
    n0 = done_cnt;
    start_cyc = cyc;
    exp_done_cyc = (lat > 0) ? cyc + exp_rel : -1;
    op_active = 1;
    start = 1; mode = m; x_in = x;
    repeat (hold) @(negedge clk);
    start = 0; mode = 1'($urandom_range(0, 1)); x_in = $urandom();
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #2;
      seen = (done_cnt != n0);
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_wait: no done within 300 cycles, expected one");
      op_active = 0;
    end
    chk("eval_count_left", exp_ex.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0; logic [31:0] t, t2, xr;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_overflow", overflow, 0); chk("rst_eval_start", eval_start, 0);
    chk("rst_value", value, 0); chk("rst_gradient", gradient, 0);
    chk("rst_x_diff", x_diff, 0); chk("rst_eval_x", eval_x, 0);
    rst = 0;
    @(negedge clk);

    fsel = 0; ovf_en = 0;
    run_op(32'h100, 0, 3, 1);
    chk("lit_b_value", value, 64'h300); chk("lit_b_grad", gradient, 72'h300);
    chk("lit_b_xdiff", x_diff, 32'h60); chk("lit_b_ovf", overflow, 0);
    chk("lit_b_done_cyc", last_rel, 10); chk("lit_b_ex1", ex_log[1], 32'hFE);
`ifdef GRAD_STEP_CENTRAL_EN
    run_op(32'h100, 1, 3, 2);
    chk("lit_c_grad", gradient, 72'h300); chk("lit_c_xdiff", x_diff, 32'h60);
    chk("lit_c_done_cyc", last_rel, 14);
    chk("lit_c_ex1", ex_log[1], 32'h102); chk("lit_c_ex2", ex_log[2], 32'hFE);
`endif

    fsel = 2; ref_x = 32'h1000; ya = 64'h7FFF_FFFF_FFFF_FFFF; yb = '0;
    run_op(32'h1000, 0, 2, 1);
    chk("lit_clamp_hi", x_diff, 32'h7FFFFFFF); chk("lit_clamp_hi_ovf", overflow, 1);
    ya = '0; yb = 64'h7FFF_FFFF_FFFF_FFFF;
    run_op(32'h1000, 0, 2, 1);
    chk("lit_clamp_lo", x_diff, 32'h80000000); chk("lit_clamp_lo_ovf", overflow, 1);

    fsel = 0;
    run_op(32'h80000000, 0, 1, 2);
    chk("lit_sat_ex1", ex_log[1], 32'h80000000); chk("lit_sat_ovf", overflow, 1);

    run_op(32'h55, 0, 0, 1);
    chk("lit_tmo_err", err, 1); chk("lit_tmo_ovf", overflow, 1);
    chk("lit_tmo_value", value, 0); chk("lit_tmo_xdiff", x_diff, 0);
    @(negedge clk); #2;
    chk("lit_tmo_idle", busy, 0);

    // reset during EVAL_M with a response still in flight
    lat_cfg = 3;
    @(negedge clk);
    exp_ex.delete(); ex_log.delete();
    model(32'h100, 0, 3);
    start_cyc = cyc; exp_done_cyc = cyc + exp_rel; op_active = 1;
    start = 1; mode = 0; x_in = 32'h100;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    rst = 1; op_active = 0; #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_value", value, 0); chk("mid_rst_grad", gradient, 0);
    chk("mid_rst_xdiff", x_diff, 0); chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_err", err, 0); chk("mid_rst_estart", eval_start, 0);
    chk("mid_rst_ex", eval_x, 0);
    @(negedge clk); rst = 0; exp_ex.delete();
    n0 = done_cnt;
    repeat (6) @(negedge clk);
    #2 chk("no_done_after_rst", done_cnt, n0);
    run_op(32'h200, 0, 2, 1);
    chk("post_rst_value", value, 64'h600);

    for (int k = 0; k < 40; k++) begin
      fsel = $urandom_range(0, 1);
      ovf_en = 1'($urandom_range(0, 1));
      t = $urandom(); t2 = $urandom();
      slope = $urandom_range(0, 1) ? t : {{16{t[15]}}, t[15:0]};
      offs = {{32{t2[31]}}, t2};
      case ($urandom_range(0, 5))
        0:       xr = 32'h7FFFFFFF - $urandom_range(0, 2);
        1:       xr = 32'h80000000 + $urandom_range(0, 2);
        default: xr = $urandom();
      endcase
      run_op(xr, 1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(1, 3));
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
